div_stream_adapter: RTL and testbench

- Valid/ready wrapper around the fixed-latency, non-stallable pipelinediv divider.
- Issues operands to the divider and carries a valid/divide-by-zero tag alongside it.
- Captures results into a show-ahead output FIFO, so a stalled consumer never loses data.
- Sits directly upstream and downstream of pipelinediv: drives its dividend/divisor and consumes its quotient/remainder.

---
 rtl/div_stream_adapter.sv | 94 +++++++++
 tb/tb_div_stream_adapter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_stream_adapter.sv
// Valid/ready wrapper around the fixed-latency pipelinediv divider.
// Tags ride alongside the divider; results land in a show-ahead FIFO.
module div_stream_adapter #(
  parameter int DIVIDEND   = 16,
  parameter int DIVISOR    = 8,
  parameter int LATENCY    = 16,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DIVIDEND-1:0] in_dividend,
  input  logic [DIVISOR-1:0]  in_divisor,
  output logic [DIVIDEND-1:0] div_dividend,
  output logic [DIVISOR-1:0]  div_divisor,
  input  logic [DIVIDEND-1:0] div_quotient,
  input  logic [DIVISOR-1:0]  div_remainder,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DIVIDEND-1:0] out_quotient,
  output logic [DIVISOR-1:0]  out_remainder,
  output logic                out_dbz,
  output logic                busy
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DIVIDEND + DIVISOR + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  logic [CW-1:0]      reserved;
  logic [AW:0]        wptr;
  logic [AW:0]        rptr;
  logic [EW-1:0]      mem [FIFO_DEPTH];
  logic [LATENCY-1:0] tag_v;
  logic [LATENCY-1:0] tag_z;
  logic [EW-1:0]      entry;
  logic [EW-1:0]      head;
  logic               accept;
  logic               pop;
  logic               wr;
  logic               dbz_in;

  assign in_ready  = !reset && (reserved < FULL);
  assign accept    = in_valid && in_ready;
  assign out_valid = (wptr != rptr);
  assign pop       = out_valid && out_ready;
  assign busy      = (reserved != '0);
  assign wr        = tag_v[LATENCY-1];
  assign dbz_in    = (in_divisor == '0);

  // Divide-by-zero results are synthesised here; divider output is ignored.
  assign entry = tag_z[LATENCY-1]
               ? {{DIVIDEND{1'b1}}, {DIVISOR{1'b0}}, 1'b1}
               : {div_quotient, div_remainder, 1'b0};

  assign head          = mem[rptr[AW-1:0]];
  assign out_quotient  = out_valid ? head[EW-1 -: DIVIDEND] : '0;
  assign out_remainder = out_valid ? head[DIVISOR:1] : '0;
  assign out_dbz       = out_valid ? head[0] : 1'b0;

  always_ff @(posedge clock) begin
    if (reset) begin
      reserved     <= '0;
      wptr         <= '0;
      rptr         <= '0;
      tag_v        <= '0;
      tag_z        <= '0;
      div_dividend <= '0;
      div_divisor  <= '0;
    end else begin
      unique case ({accept, pop})
        2'b10:   reserved <= reserved + 1'b1;
        2'b01:   reserved <= reserved - 1'b1;
        default: reserved <= reserved;
      endcase
      div_dividend <= accept ? in_dividend : '0;
      div_divisor  <= accept ? in_divisor : '0;
      tag_v <= {tag_v[LATENCY-2:0], accept};
      tag_z <= {tag_z[LATENCY-2:0], accept && dbz_in};
      if (wr)
        wptr <= wptr + 1'b1;
      if (pop)
        rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && wr)
      mem[wptr[AW-1:0]] <= entry;
  end

endmodule

// File: tb/tb_div_stream_adapter.sv
// Directed bench for div_stream_adapter.
// Includes a behavioural pipelinediv model.
module tb_div_stream_adapter;

  localparam int LAT = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_dividend;
  logic [7:0]  in_divisor;
  logic [15:0] div_dividend;
  logic [7:0]  div_divisor;
  logic [15:0] div_quotient;
  logic [7:0]  div_remainder;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_quotient;
  logic [7:0]  out_remainder;
  logic        out_dbz;
  logic        busy;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  div_stream_adapter #(
    .DIVIDEND(16), .DIVISOR(8),
    .LATENCY(LAT), .FIFO_DEPTH(32)
  ) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dividend(in_dividend), .in_divisor(in_divisor),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_quotient(out_quotient), .out_remainder(out_remainder),
    .out_dbz(out_dbz), .busy(busy)
  );

  // pipelinediv model: LAT-1 register stages, garbage on divide by zero
  logic [15:0] mq [LAT-1];
  logic [7:0]  mr [LAT-1];
  always @(posedge clock) begin
    for (int i = LAT - 2; i > 0; i--) begin
      mq[i] <= mq[i-1];
      mr[i] <= mr[i-1];
    end
    if (div_divisor == 0) begin
      mq[0] <= 16'h1234;
      mr[0] <= 8'hAB;
    end else begin
      mq[0] <= div_dividend / 16'(div_divisor);
      mr[0] <= 8'(div_dividend % 16'(div_divisor));
    end
  end
  assign div_quotient  = mq[LAT-2];
  assign div_remainder = mr[LAT-2];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 200) begin
      step();
      n++;
    end
    if (n >= 200)
      check("wait_valid_timeout", 1, 0);
  endtask

  task automatic send(input logic [15:0] a,
                      input logic [7:0] b);
    in_valid    = 1'b1;
    in_dividend = a;
    in_divisor  = b;
    step();
    in_valid = 1'b0;
  endtask

  int n, acc, rx, bub, stall, seen;
  logic [15:0] ra [100];
  logic [7:0]  rb [100];

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_dividend = '0;
    in_divisor = '0;
    out_ready = 1'b1;
    for (int i = 0; i < LAT - 1; i++) begin
      mq[i] = '0;
      mr[i] = '0;
    end
    step();
    step();
    check("rst_in_ready", in_ready, 0);
    reset = 1'b0;
    #1;
    check("rst_rel_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_q", out_quotient, 0);

    // single op latency and pulse
    send(16'd1000, 8'd7);
    wait_valid(n);
    check("lat1", n, LAT);
    check("q1000_7", out_quotient, 142);
    check("r1000_7", out_remainder, 6);
    check("dbz1000_7", out_dbz, 0);
    step();
    check("pulse1", out_valid, 0);
    check("busy1", busy, 0);
    check("q_empty", out_quotient, 0);

    // divide by zero then normal op
    in_valid = 1'b1;
    in_dividend = 16'd500;
    in_divisor = 8'd0;
    step();
    in_dividend = 16'd65535;
    in_divisor = 8'd255;
    step();
    in_valid = 1'b0;
    wait_valid(n);
    check("lat_dbz", n, LAT - 1);
    check("q_dbz", out_quotient, 16'hFFFF);
    check("r_dbz", out_remainder, 0);
    check("f_dbz", out_dbz, 1);
    step();
    check("v_65535", out_valid, 1);
    check("q_65535", out_quotient, 257);
    check("r_65535", out_remainder, 0);
    check("f_65535", out_dbz, 0);
    step();
    check("busy2", busy, 0);

    // fill with consumer stalled
    out_ready = 1'b0;
    acc = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      in_dividend = 16'(acc);
      in_divisor = 8'd3;
      if (in_ready)
        acc++;
      step();
    end
    in_valid = 1'b0;
    check("fill_count", acc, 32);
    check("fill_ready", in_ready, 0);
    for (int c = 0; c < 20; c++)
      step();
    check("full_still", in_ready, 0);
    out_ready = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) begin
      check("drain_v", out_valid, 1);
      check("drain_q", out_quotient, i / 3);
      check("drain_r", out_remainder, i % 3);
      step();
      if (i == 0)
        check("ready_after_pop", in_ready, 1);
    end
    check("drain_empty", out_valid, 0);
    check("drain_busy", busy, 0);

    // full with simultaneous pop and request
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_divisor = 8'd5;
    acc = 0;
    for (int c = 0; c < 40; c++) begin
      in_dividend = 16'(100 + acc);
      if (in_ready)
        acc++;
      step();
    end
    for (int c = 0; c < 20; c++)
      step();
    check("fill2", acc, 32);
    in_dividend = 16'd200;
    in_divisor = 8'd10;
    out_ready = 1'b1;
    #1;
    check("full_pop_rdy", in_ready, 0);
    step();
    out_ready = 1'b0;
    check("rdy_next", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("refull", in_ready, 0);
    check("refull_busy", busy, 1);
    out_ready = 1'b1;
    for (int j = 0; j < 32; j++) begin
      wait_valid(n);
      check("drain2_q", out_quotient,
            (j < 31) ? (101 + j) / 5 : 20);
      step();
    end
    check("drain2_busy", busy, 0);

    // back-to-back random stream
    for (int i = 0; i < 100; i++) begin
      ra[i] = 16'($urandom);
      rb[i] = 8'($urandom_range(1, 255));
    end
    rx = 0;
    bub = 0;
    stall = 0;
    for (int t = 0; t < 160; t++) begin
      if (out_valid) begin
        if (rx < 100)
          check("stream_qr",
                {out_quotient, out_remainder},
                {ra[rx] / 16'(rb[rx]),
                 8'(ra[rx] % 16'(rb[rx]))});
        rx++;
      end else if (rx > 0 && rx < 100) begin
        bub++;
      end
      if (t < 100) begin
        in_valid = 1'b1;
        in_dividend = ra[t];
        in_divisor = rb[t];
        #1;
        if (!in_ready)
          stall++;
      end else begin
        in_valid = 1'b0;
      end
      step();
    end
    check("stream_count", rx, 100);
    check("stream_bubbles", bub, 0);
    check("stream_stalls", stall, 0);

    // reset with ops in flight and buffered
    out_ready = 1'b0;
    send(16'd11, 8'd1);
    send(16'd12, 8'd1);
    for (int c = 0; c < 17; c++)
      step();
    check("buffered", out_valid, 1);
    send(16'd13, 8'd1);
    send(16'd14, 8'd1);
    send(16'd15, 8'd1);
    reset = 1'b1;
    #1;
    check("rst_mid_rdy", in_ready, 0);
    step();
    reset = 1'b0;
    #1;
    check("post_rst_rdy", in_ready, 1);
    check("post_rst_busy", busy, 0);
    check("post_rst_v", out_valid, 0);
    check("post_rst_q", out_quotient, 0);
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid)
        seen++;
      step();
    end
    check("ghost_results", seen, 0);
    send(16'd255, 8'd16);
    wait_valid(n);
    check("q255_16", out_quotient, 15);
    check("r255_16", out_remainder, 15);
    check("f255_16", out_dbz, 0);
    step();
    check("final_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
